// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw active-low buttons in, press pulses and debounced levels out
interface button_conditioner_if;
  logic btn_next_n;
  logic btn_inc_n;
  logic btn_prev_n;
  logic pulse_next;
  logic pulse_inc;
  logic pulse_prev;
  logic [2:0] btn_level;
  modport master (
    output btn_next_n, btn_inc_n, btn_prev_n,
    input  pulse_next, pulse_inc, pulse_prev, btn_level
  );
  modport slave (
    input  btn_next_n, btn_inc_n, btn_prev_n,
    output pulse_next, pulse_inc, pulse_prev, btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync + debounce three buttons into press pulses; autorepeat under BUTTON_CONDITIONER_AUTOREPEAT_EN
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic clk,
  input logic reset,
  button_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0] raw, sync1, sync2, level, level_d, cand;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end
  // Inverting ahead of the flops keeps every synchronizer stage at 0 = released under reset
  assign raw = ~{bus.btn_prev_n, bus.btn_inc_n, bus.btn_next_n};
  // two-flop synchronizer per button
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  // previous debounced level, used to spot a fresh 0->1 flip
  always_ff @(posedge clk or posedge reset)
    if (reset) level_d <= '0;
    else level_d <= level;
  genvar i;
  for (i = 0; i < 3; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic lvl;
    assign level[i] = lvl;
    // debounce: count consecutive disagreeing cycles, flip once the run is long enough
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic [HW-1:0] rem;
    logic press, held;
    assign press = lvl & ~level_d[i];
    assign held  = lvl & level_d[i];
    // countdown to next repeat: armed by the press, reloaded on each repeat, cleared on release
    always_ff @(posedge clk or posedge reset)
      if (reset) rem <= '0;
      else rem <= press ? HW'(REPEAT_DELAY - 1) : !held ? '0 : (rem == '0) ? HW'(REPEAT_PERIOD - 1) : rem - 1'b1;
    assign cand[i] = press | (held & (rem == '0));
`else
    assign cand[i] = lvl & ~level_d[i];
`endif
  end
  // registered pulses; next and prev are mutually exclusive with next taking priority
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.pulse_next <= 1'b0;
      bus.pulse_inc  <= 1'b0;
      bus.pulse_prev <= 1'b0;
    end else begin
      bus.pulse_next <= cand[0];
      bus.pulse_inc  <= cand[1];
      bus.pulse_prev <= cand[2] & ~cand[0];
    end
  assign bus.btn_level = level;
endmodule
